arb_mux_reg: RTL and testbench
==============================

Name: arb_mux_reg

Overview:
- Parametrised, registered N:1 data selector with valid/ready handshake on every input channel and on the output.
- Two modes: round-robin arbitration among valid channels, or fixed selection driven by a select input.
- Generalises the 16:1 single-bit selector to configurable width and channel count, and adds a registered output stage with backpressure.
- Sits between multiple producers (e.g. memory/IO request sources) and a single consumer in the CompactRISC16 datapath.

Parameters:
- WIDTH, 16, data bits per channel.
- CHANNELS, 16, number of input channels (>=2).
- SEL_W, $clog2(CHANNELS), width of select and grant-index signals.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = round-robin, 1 = fixed select
- sel  in  SEL_W  channel index used when mode=1
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  per-channel ready; at most one bit high per cycle
- out_data  out  WIDTH  registered selected data
- out_sel  out  SEL_W  registered index of the channel that produced out_data
- out_valid  out  1  output holds a word
- out_ready  in  1  consumer accepts the word

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, in_ready=0, rr pointer=CHANNELS-1 (first search starts at channel 0). Assertion mid-operation drops any held word; no partial transfers survive.
- load_en = ~out_valid | out_ready (output register empty or draining this cycle).
- Grant, combinational, one-hot or zero:
  - mode=0: first i with in_valid[i], searching from (ptr+1) mod CHANNELS upward with wrap.
  - mode=1: grant[sel] = in_valid[sel]. Zero if sel >= CHANNELS.
- in_ready = grant & {CHANNELS{load_en}}. A combinational in_valid->in_ready path is permitted; in_ready never depends on in_data.
- Input transfer on channel i: in_valid[i] & in_ready[i]. On the next edge, out_data <= channel i data, out_sel <= i, out_valid <= 1, ptr <= i. ptr updates in both modes.
- No transfer and out_ready=1: out_valid <= 0; out_data and out_sel hold.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready stays high (simultaneous drain and load).
- Backpressure: while out_valid & ~out_ready, out_data, out_sel and out_valid are stable and all in_ready=0.
- Fairness: in mode=0 with all channels valid continuously, grants rotate 0,1,...,CHANNELS-1,0. A channel waits at most CHANNELS-1 transfers.
- Mode or sel change takes effect on the same cycle's grant. A held output word is unaffected.
- No valid channel: grant=0, no transfer, ptr holds.

Decomposition:
- Shared package:
  - MODE_RR=1'b0, MODE_FIXED=1'b1.
  - clog2 helper function, used for SEL_W.
- One sub-module: rr_arbiter (CHANNELS param; inputs req, ptr, en; outputs one-hot grant and encoded index).
  - Implemented as rotate, priority-pick, rotate back.
- The data mux is an AND-OR of the one-hot grant, in the top level.

Test Plan (WIDTH=16, CHANNELS=16):
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0. Release -> first grant channel 0; one cycle later out_data=ch0 data, out_sel=0.
- Round-robin: all in_valid=1, in_data[i]=16'hA000+i, out_ready=1 -> out_sel sequence 0..15,0; one word per cycle; in_ready one-hot each cycle.
- Sparse requesters: in_valid=16'h8001 with ptr at 0 -> grant 15, then 0, then 15 (wrap across the index boundary).
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_sel stable, in_ready=0. out_ready=1 -> drain and reload in the same cycle.
- Fixed mode: mode=1, sel=5, in_valid=16'hFFFF -> only ch5 granted repeatedly. sel=5'd… beyond range is untestable at 16 channels; repeat with CHANNELS=12 and sel=13 -> no grant, out_valid falls to 0.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 immediately (async). Word is lost; ptr back to 15.

Source files
------------

// File: rtl/arb_mux_reg_pkg.sv
// Shared definitions for the registered N:1 arbitrating selector.
package arb_mux_reg_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Number of bits needed to encode n distinct values (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Round-robin arbiter: rotate requests so the search starts just after the
// last winner, take the lowest set bit, then rotate the one-hot result back.
module arb_mux_reg_rr_arbiter
  import arb_mux_reg_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                en,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    idx
);

  logic [SEL_W-1:0]    start;
  logic [CHANNELS-1:0] rot;
  logic [CHANNELS-1:0] oh_rot;
  logic [SEL_W-1:0]    pick;
  logic                found;
  logic [SEL_W:0]      sum;

  // Rotate requests right so bit 0 is the channel after the previous winner.
  always_comb begin
    start = (ptr == SEL_W'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
    rot   = CHANNELS'({req, req} >> start);
  end

  // Lowest-index pick in the rotated frame.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    oh_rot = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (!found && rot[j]) begin
        found     = 1'b1;
        pick      = SEL_W'(j);
        oh_rot[j] = 1'b1;
      end
    end
  end

  // Rotate the winner back into channel numbering, both one-hot and encoded.
  always_comb begin
    sum = {1'b0, pick} + {1'b0, start};
    if (sum >= (SEL_W + 1)'(CHANNELS)) sum = sum - (SEL_W + 1)'(CHANNELS);
    idx   = sum[SEL_W-1:0];
    grant = (en && found) ? CHANNELS'(({oh_rot, oh_rot} << start) >> CHANNELS) : '0;
  end

endmodule

// File: rtl/arb_mux_reg.sv
// Registered N:1 selector with valid/ready on every channel and on the output.
// Round-robin or fixed-select arbitration feeds a one-word output register.
module arb_mux_reg
  import arb_mux_reg_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                load_en;
  logic                take;
  logic [SEL_W-1:0]    ptr;
  logic [CHANNELS-1:0] rr_grant;
  logic [SEL_W-1:0]    rr_idx;
  logic [CHANNELS-1:0] fixed_grant;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    mux_data;

  // The output register can accept a word when empty or draining this cycle.
  assign load_en = ~out_valid | out_ready;

  arb_mux_reg_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr (
    .req   (in_valid),
    .ptr   (ptr),
    .en    (mode == MODE_RR),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Fixed mode grants only the selected channel; out-of-range sel grants none.
  always_comb begin
    fixed_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fixed_grant[i] = (sel == SEL_W'(i)) & in_valid[i];
    end
  end

  // Pick the active grant source for this cycle.
  always_comb begin
    grant     = (mode == MODE_FIXED) ? fixed_grant : rr_grant;
    grant_idx = (mode == MODE_FIXED) ? sel : rr_idx;
  end

  // Ready is withheld during reset and while the held word is backpressured.
  assign in_ready = grant & {CHANNELS{load_en & rst_n}};
  assign take     = |in_ready;

  // AND-OR data mux driven by the one-hot grant.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // Output register and round-robin pointer: load on transfer, clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= grant_idx;
      ptr       <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: constant vector table, hand sequences for rotation,
// async reset and out-of-range select, and a randomized run against a model.
module tb_arb_mux_reg;

  localparam int W  = 16;
  localparam int C  = 16;
  localparam int S  = 4;
  localparam int C2 = 12;
  localparam int S2 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           mode;
  logic [S-1:0]   sel;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_sel;
  logic           out_valid, out_ready;

  logic            b_mode;
  logic [S2-1:0]   b_sel;
  logic [C2*W-1:0] b_in_data;
  logic [C2-1:0]   b_in_valid, b_in_ready;
  logic [W-1:0]    b_out_data;
  logic [S2-1:0]   b_out_sel;
  logic            b_out_valid, b_out_ready;

  arb_mux_reg #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  arb_mux_reg #(.WIDTH(W), .CHANNELS(C2)) dut12 (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel), .in_data(b_in_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model state: the output holding register and the last winner.
  int          m_ptr;
  bit          m_ov;
  logic [15:0] m_od;
  int          m_os;

  // Winner among n channels by the selection rules; -1 when nobody wins.
  function automatic int pick(input int n, input int ptr, input bit md,
                              input int s, input logic [15:0] v);
    if (md) return (s < n && v[s]) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [C*W-1:0] ramp();
    logic [C*W-1:0] d;
    for (int i = 0; i < C; i++) d[i*W +: W] = 16'hA000 + 16'(i);
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = '1; out_ready = 1'b1; mode = 1'b0; sel = '0;
    in_data = ramp();
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = '0; rst_n = 1'b1;
    m_ptr = C - 1; m_ov = 1'b0; m_od = '0; m_os = 0;
  endtask

  // One cycle on the 16-channel DUT, checked against the model.
  task automatic cyc16(input bit md, input int s, input logic [15:0] v,
                       input bit ordy, input logic [C*W-1:0] d);
    int c;
    logic [15:0] exp_rdy;
    @(negedge clk);
    mode = md; sel = S'(s); in_valid = v; out_ready = ordy; in_data = d;
    #1;
    chk("rand out_valid", 32'(out_valid), 32'(m_ov));
    chk("rand out_sel", 32'(out_sel), 32'(m_os));
    chk("rand out_data", 32'(out_data), 32'(m_od));
    c = pick(C, m_ptr, md, s, v);
    exp_rdy = (c >= 0 && (!m_ov || ordy)) ? (16'd1 << c) : 16'd0;
    chk("rand in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy != 0) begin
      m_ov = 1'b1; m_od = d[c*W +: W]; m_os = c; m_ptr = c;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  typedef struct {
    bit          md;
    logic [3:0]  s;
    logic [15:0] v;
    bit          ordy;
    logic [15:0] rdy;
    bit          ov;
    logic [3:0]  os;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rst_n = 1'b0;
    mode = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b1; in_data = ramp();
    b_mode = 1'b1; b_sel = 4'd4; b_in_valid = '1; b_out_ready = 1'b1;
    for (int i = 0; i < C2; i++) b_in_data[i*W +: W] = 16'hB000 + 16'(i);

    tbl[0]  = '{1'b0, 4'd0, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 4'd0};
    tbl[1]  = '{1'b0, 4'd0, 16'hFFFF, 1'b1, 16'h0002, 1'b1, 4'd1};
    tbl[2]  = '{1'b0, 4'd0, 16'h8001, 1'b1, 16'h8000, 1'b1, 4'd15};
    tbl[3]  = '{1'b0, 4'd0, 16'h8001, 1'b1, 16'h0001, 1'b1, 4'd0};
    tbl[4]  = '{1'b0, 4'd0, 16'h8001, 1'b1, 16'h8000, 1'b1, 4'd15};
    tbl[5]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd15};
    tbl[6]  = '{1'b1, 4'd5, 16'hFFFF, 1'b1, 16'h0020, 1'b1, 4'd5};
    tbl[7]  = '{1'b1, 4'd5, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 4'd5};
    tbl[8]  = '{1'b1, 4'd5, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 4'd5};
    tbl[9]  = '{1'b0, 4'd0, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 4'd5};
    tbl[10] = '{1'b0, 4'd0, 16'hFFFF, 1'b1, 16'h0040, 1'b1, 4'd6};
    tbl[11] = '{1'b1, 4'd3, 16'h0004, 1'b1, 16'h0000, 1'b0, 4'd6};
    tbl[12] = '{1'b0, 4'd0, 16'h0004, 1'b1, 16'h0004, 1'b1, 4'd2};

    // Vector table from a fresh reset.
    do_reset();
    for (int r = 0; r < 13; r++) begin
      @(negedge clk);
      mode = tbl[r].md; sel = tbl[r].s; in_valid = tbl[r].v; out_ready = tbl[r].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", r), 32'(in_ready), 32'(tbl[r].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", r), 32'(out_valid), 32'(tbl[r].ov));
      chk($sformatf("vec%0d out_sel", r), 32'(out_sel), 32'(tbl[r].os));
      chk($sformatf("vec%0d out_data", r), 32'(out_data), 32'(16'hA000 + 16'(tbl[r].os)));
    end

    // Full rotation with all channels requesting: 0..15 then 0 again.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      mode = 1'b0; in_valid = '1; out_ready = 1'b1;
      #1;
      if (k < 17) chk($sformatf("rot%0d in_ready", k), 32'(in_ready), 32'(16'd1 << (k % 16)));
      if (k > 0) begin
        chk($sformatf("rot%0d out_sel", k), 32'(out_sel), 32'((k - 1) % 16));
        chk($sformatf("rot%0d out_valid", k), 32'(out_valid), 32'd1);
      end
    end

    // Asynchronous reset while a word is held under backpressure.
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("hold out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_data", 32'(out_data), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = '1; mode = 1'b0;
    #1;
    chk("post rst first grant", 32'(in_ready), 32'h0001);

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [C*W-1:0] d;
      logic [15:0] v;
      for (int i = 0; i < C; i++) d[i*W +: W] = 16'($urandom);
      v = ($urandom_range(0, 1) == 0) ? 16'($urandom & $urandom & $urandom) : 16'($urandom);
      cyc16(($urandom_range(0, 3) == 0), $urandom_range(0, C - 1), v,
            ($urandom_range(0, 3) != 0), d);
    end

    // Twelve-channel instance: in-range select, then out-of-range select.
    do_reset();
    @(negedge clk);
    b_mode = 1'b1; b_sel = 4'd4; b_in_valid = '1; b_out_ready = 1'b1;
    #1;
    chk("c12 sel4 in_ready", 32'(b_in_ready), 32'h010);
    @(posedge clk);
    #1;
    chk("c12 sel4 out_valid", 32'(b_out_valid), 32'd1);
    chk("c12 sel4 out_data", 32'(b_out_data), 32'hB004);
    @(negedge clk);
    b_sel = 4'd13;
    #1;
    chk("c12 sel13 in_ready", 32'(b_in_ready), 32'h000);
    @(posedge clk);
    #1;
    chk("c12 sel13 out_valid", 32'(b_out_valid), 32'd0);
    chk("c12 sel13 out_sel", 32'(b_out_sel), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
